lcd1602_reader: RTL
===================

Name: lcd1602_reader

Overview:
Read-side bus engine for the HD44780/LCD1602 8-bit parallel interface; the counterpart of the team's write-only init/print sequencer.
Performs single status reads (RS=0, RW=1), single DDRAM/CGRAM data reads (RS=1, RW=1), and a busy-flag poll loop, so writers can wait on BF instead of using fixed delays.
Sits between the LCD top level and the write sequencer. The top level tri-states its dat driver whenever lcd_rw=1.

Parameters:
T_AS_CYC, 4, clk cycles RS/RW setup before EN rises (>=60 ns at 50 MHz)
T_EH_CYC, 25, clk cycles EN high (>=450 ns); data sampled on the last of these cycles
T_EL_CYC, 25, clk cycles EN low after the fall, covering hold and the 1 us min cycle time
POLL_MAX, 4096, max status reads per poll request before timeout (width 13 bits)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
req  in  1  start request; accepted only while busy=0
req_rs  in  1  0=status read, 1=data read; ignored when req_poll=1
req_poll  in  1  1=repeat status reads until BF=0 or timeout
busy  out  1  high from the cycle after accept until the cycle after done
done  out  1  one-cycle pulse at the end of a request
timeout  out  1  poll ended with BF still 1; held until the next accept
rd_data  out  8  last sampled byte
bf  out  1  busy flag from the last status read (rd_data[7])
ac  out  7  address counter from the last status read (rd_data[6:0])
lcd_rs  out  1  LCD RS pin
lcd_rw  out  1  LCD RW pin; 1 only during SETUP/EN_HI/HOLD
lcd_en  out  1  LCD E pin
lcd_dat_i  in  8  LCD data bus input (from the pad)

Behaviour:
- Reset values: busy=0, done=0, timeout=0, rd_data=0, bf=0, ac=0, lcd_rs=0, lcd_rw=0, lcd_en=0, state=IDLE, counters=0.
- Reset mid-transfer: on the next edge all outputs return to reset values. EN drops immediately. No done pulse.
- States: IDLE, SETUP, EN_HI, HOLD, DONE.
- IDLE: if req=1, latch mode (rs_l = req_poll ? 0 : req_rs; poll_l = req_poll), clear timeout, clear poll_cnt, then go to SETUP. If req=0, stay.
- SETUP: lcd_rw=1, lcd_rs=rs_l, lcd_en=0 for exactly T_AS_CYC cycles, then go to EN_HI.
- EN_HI: lcd_en=1 for exactly T_EH_CYC cycles.
  - On the final EN_HI edge, rd_data<=lcd_dat_i.
  - If rs_l=0, also update bf and ac from the same byte.
  - Then go to HOLD.
- HOLD: lcd_en=0, lcd_rw=1, lcd_rs held, for T_EL_CYC cycles. On exit:
  - If poll_l=1, bf=1 and poll_cnt+1 < POLL_MAX: poll_cnt++, go to SETUP (RS/RW stay asserted; no IDLE gap).
  - If poll_l=1, bf=1 and poll_cnt+1 = POLL_MAX: timeout<=1, go to DONE.
  - Otherwise go to DONE.
- DONE: done=1 for one cycle, lcd_rw<=0, lcd_rs<=0, then go to IDLE. busy falls on the following edge.
- Latency: req sampled at edge k gives lcd_rw=1 from k+1, lcd_en rise at k+1+T_AS_CYC, and done at k+1+T_AS_CYC+T_EH_CYC+T_EL_CYC (k+55 with defaults). Each extra poll iteration adds T_AS+T_EH+T_EL = 54 cycles.
- Requests arriving while busy=1, including the DONE cycle, are ignored with no queueing. A req held high re-triggers in IDLE.
- Timing counters are down-counters loaded with (N-1), so each phase lasts exactly N cycles. Parameters must be >= 1.
- A data read does not change bf/ac.
- The poll counter saturates: no wrap is possible because the loop exits at POLL_MAX.

Decomposition:
- lcd1602_pkg, shared with the write sequencer:
  - state enum
  - RS_CMD=0, RS_DATA=1, RW_WR=0, RW_RD=1
  - BF_BIT=7
  - HD44780 command constants (0x38, 0x0C, 0x06, 0x01, 0x80)
- One sub-module, lcd_phase_timer: loadable down-counter with load, value and zero flag. It is reused for the SETUP, EN_HI and HOLD phases.

Test Plan:
- Status read: lcd_dat_i=0x45, req=1, req_rs=0 -> lcd_rw=1 and lcd_rs=0 for the whole cycle; lcd_en high exactly 25 cycles; done at k+55; rd_data=0x45, bf=0, ac=0x45.
- Data read: rd_data and ac preset to 0x12 from a prior status read, lcd_dat_i=0x48 ('H'), req_rs=1 -> lcd_rs=1; rd_data=0x48; bf/ac unchanged (0/0x12).
- Poll: model drives 0x80|AC for 3 reads, then 0x07 -> exactly 4 EN pulses; done at k+1+4*54; bf=0, ac=0x07, timeout=0.
- Poll timeout: run with POLL_MAX=3 and lcd_dat_i fixed at 0x80 -> 3 EN pulses; done with timeout=1; the next accept clears timeout.
- Collision and reset: pulse req during EN_HI -> ignored, single done. Assert rst mid-EN_HI -> lcd_en=0, lcd_rw=0, busy=0 on the next edge; no done pulse.

Source files
------------

// File: rtl/lcd1602_pkg.sv
// Shared definitions for the HD44780/LCD1602 8-bit bus engines (reader and write sequencer).
package lcd1602_pkg;

    // Bus engine phases. IDLE waits for a request, SETUP holds RS/RW ahead of E,
    // EN_HI is the E pulse, HOLD covers hold time and minimum cycle time, DONE pulses done.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EN_HI = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } lcd_state_t;

    // RS / RW pin levels
    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;
    localparam logic RW_WR   = 1'b0;
    localparam logic RW_RD   = 1'b1;

    // Busy flag position in the status byte; the low 7 bits are the address counter
    localparam int BF_BIT = 7;

    // HD44780 commands used by the write sequencer
    localparam logic [7:0] CMD_FUNC_SET_8B = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON     = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_ENTRY_INC   = 8'h06;  // increment address, no shift
    localparam logic [7:0] CMD_CLEAR       = 8'h01;  // clear display
    localparam logic [7:0] CMD_SET_DDRAM   = 8'h80;  // set DDRAM address (OR in address)

    // Width of a down-counter that must hold (N-1) for the largest of three phase lengths
    function automatic int phase_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter used to time each bus phase; loading (N-1) gives a phase of N cycles.
module lcd_phase_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_value,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load on request, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_value = r_cnt;
    assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/lcd1602_reader.sv
// Read-side bus engine for the LCD1602: single status reads, single data reads, and a
// busy-flag poll loop that repeats status reads until BF=0 or POLL_MAX reads were made.
//
// Handshake: req is accepted on a clock edge where the engine is in IDLE (busy=0); busy
// rises on that edge and stays high through the DONE cycle; done pulses for exactly one
// cycle when the request finishes. Requests while busy=1 are dropped, never queued.
module lcd1602_reader
    import lcd1602_pkg::*;
#(
    parameter int T_AS_CYC = 4,
    parameter int T_EH_CYC = 25,
    parameter int T_EL_CYC = 25,
    parameter int POLL_MAX = 4096,
    localparam int PHASE_W = phase_width(T_AS_CYC, T_EH_CYC, T_EL_CYC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               req_rs,
    input  logic               req_poll,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [7:0]         rd_data,
    output logic               bf,
    output logic [6:0]         ac,
    output logic               lcd_rs,
    output logic               lcd_rw,
    output logic               lcd_en,
    input  logic [7:0]         lcd_dat_i,
    output lcd_state_t         dbg_state,
    output logic [PHASE_W-1:0] dbg_phase_cnt
);

    localparam int PCW = $clog2(POLL_MAX + 1);

    lcd_state_t         r_state;
    logic               r_rs_l;
    logic               r_poll_l;
    logic [PCW-1:0]     r_poll_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
    logic [7:0]         r_rd_data;
    logic               r_bf;
    logic [6:0]         r_ac;
    logic               r_lcd_rs;
    logic               r_lcd_rw;
    logic               r_lcd_en;

    logic               w_tmr_load;
    logic [PHASE_W-1:0] w_tmr_val;
    logic [PHASE_W-1:0] w_tmr_value;
    logic               w_tmr_zero;
    logic               w_poll_again;
    logic               w_rs_sel;

    // A poll request always reads status, whatever req_rs says
    assign w_rs_sel = req_poll ? RS_CMD : req_rs;

    lcd_phase_timer #(
        .W (PHASE_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_value    (w_tmr_value),
        .o_zero     (w_tmr_zero)
    );

    // Phase timer reload at every phase boundary, and the poll-continue decision
    always_comb begin
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        w_poll_again = r_poll_l && r_bf && ((int'(r_poll_cnt) + 1) < POLL_MAX);
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = PHASE_W'(T_AS_CYC - 1);
                end
            end
            ST_SETUP: begin
                if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = PHASE_W'(T_EH_CYC - 1);
                end
            end
            ST_EN_HI: begin
                if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = PHASE_W'(T_EL_CYC - 1);
                end
            end
            ST_HOLD: begin
                if (w_tmr_zero && w_poll_again) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = PHASE_W'(T_AS_CYC - 1);
                end
            end
            default: ;
        endcase
    end

    // Bus FSM with registered pin and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rs_l     <= RS_CMD;
            r_poll_l   <= 1'b0;
            r_poll_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_rd_data  <= '0;
            r_bf       <= 1'b0;
            r_ac       <= '0;
            r_lcd_rs   <= RS_CMD;
            r_lcd_rw   <= RW_WR;
            r_lcd_en   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_rs_l     <= w_rs_sel;
                        r_poll_l   <= req_poll;
                        r_timeout  <= 1'b0;
                        r_poll_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_lcd_rs   <= w_rs_sel;
                        r_lcd_rw   <= RW_RD;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_tmr_zero) begin
                        r_lcd_en <= 1'b1;
                        r_state  <= ST_EN_HI;
                    end
                end
                ST_EN_HI: begin
                    // The bus is sampled on the last E-high edge, just as E falls
                    if (w_tmr_zero) begin
                        r_lcd_en  <= 1'b0;
                        r_rd_data <= lcd_dat_i;
                        if (r_rs_l == RS_CMD) begin
                            r_bf <= lcd_dat_i[BF_BIT];
                            r_ac <= lcd_dat_i[6:0];
                        end
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_tmr_zero) begin
                        if (w_poll_again) begin
                            // RS/RW stay asserted; the next status read starts without an IDLE gap
                            r_poll_cnt <= r_poll_cnt + 1'b1;
                            r_state    <= ST_SETUP;
                        end else begin
                            if (r_poll_l && r_bf) begin
                                r_timeout <= 1'b1;
                            end
                            r_done   <= 1'b1;
                            r_lcd_rw <= RW_WR;
                            r_lcd_rs <= RS_CMD;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign timeout       = r_timeout;
    assign rd_data       = r_rd_data;
    assign bf            = r_bf;
    assign ac            = r_ac;
    assign lcd_rs        = r_lcd_rs;
    assign lcd_rw        = r_lcd_rw;
    assign lcd_en        = r_lcd_en;
    assign dbg_state     = r_state;
    assign dbg_phase_cnt = w_tmr_value;

endmodule
